// File: rtl/prim_delay_pkg.sv
// Shared constants and helpers for the programmable delay line.
package prim_delay_pkg;

  localparam logic MODE_TRANSPORT = 1'b0;
  localparam logic MODE_INERTIAL  = 1'b1;

  // Zero would mean "no register", which the line cannot express; pin to 1..max.
  function automatic int unsigned clamp_delay(int unsigned delay_in, int unsigned max_delay);
    int unsigned d;
    d = delay_in;
    if (delay_in == 0) d = 1;
    else if (delay_in > max_delay) d = max_delay;
    return d;
  endfunction

endpackage

// File: rtl/prim_delay_line_if.sv
// Data/config bus of the delay line; master drives stimulus, slave is the line.
interface prim_delay_line_if #(
  parameter int WIDTH     = 4,
  parameter int MAX_DELAY = 15
);
  localparam int DW = $clog2(MAX_DELAY + 1);

  logic [WIDTH-1:0] din;
  logic             cfg_load;
  logic [DW-1:0]    delay_in;
  logic             mode_in;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] pulse_drop;
  logic [DW-1:0]    active_delay;
  logic             active_mode;

  modport master (
    output din, cfg_load, delay_in, mode_in,
    input  dout, pulse_drop, active_delay, active_mode
  );

  modport slave (
    input  din, cfg_load, delay_in, mode_in,
    output dout, pulse_drop, active_delay, active_mode
  );
endinterface

// File: rtl/prim_delay_line_inertial_filter_bit.sv
// One bit of the inertial filter: run-length counter against the current output.
module inertial_filter_bit
  import prim_delay_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          flush_i,
  input  logic          din_i,
  input  logic          dout_i,
  input  logic [DW-1:0] delay_i,
  output logic          dout_o,
  output logic          drop_o
);

  logic [DW-1:0] cnt_q, cnt_d;
  logic          drop_q, drop_d;

  // Counter and flag fall to zero whenever the filter is idle or being flushed.
  always_comb begin
    cnt_d  = '0;
    drop_d = 1'b0;
    dout_o = dout_i;
    if (en_i && !flush_i) begin
      if (din_i == dout_i)                   drop_d = (cnt_q != '0);
      else if (cnt_q >= delay_i - DW'(1))    dout_o = din_i;
      else                                   cnt_d  = cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end

  assign drop_o = drop_q;

endmodule

// File: rtl/prim_delay_line.sv
// Run-time programmable transport/inertial delay line with per-bit reject flags.
module prim_delay_line
  import prim_delay_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MAX_DELAY   = 15,
  parameter int RESET_DELAY = 1
) (
  input logic               clk,
  input logic               rst_n,
  prim_delay_line_if.slave  bus
);

  localparam int DW   = $clog2(MAX_DELAY + 1);
  localparam int SR_N = (MAX_DELAY > 1) ? MAX_DELAY - 1 : 1;

  logic [DW-1:0]              delay_q, delay_d;
  logic                       mode_q, mode_d;
  logic [SR_N-1:0][WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0]           dout_q, dout_d;
  logic [WIDTH-1:0]           tap, filt_dout, drop;

  // Stage k holds din from k+1 edges ago; the output register is the last stage.
  always_comb begin
    tap = bus.din;
    for (int k = 0; k < SR_N; k++)
      if (int'(delay_q) == k + 2) tap = sr_q[k];
  end

  always_comb begin
    delay_d = delay_q;
    mode_d  = mode_q;
    sr_d    = sr_q;
    dout_d  = dout_q;
    if (bus.cfg_load) begin
      // Flush with the held output so the new setting starts glitch-free.
      delay_d = DW'(clamp_delay(32'(bus.delay_in), MAX_DELAY));
      mode_d  = bus.mode_in;
      for (int k = 0; k < SR_N; k++) sr_d[k] = dout_q;
    end else begin
      for (int k = SR_N - 1; k > 0; k--) sr_d[k] = sr_q[k-1];
      sr_d[0] = bus.din;
      dout_d  = (mode_q == MODE_INERTIAL) ? filt_dout : tap;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      delay_q <= DW'(RESET_DELAY);
      mode_q  <= MODE_TRANSPORT;
      sr_q    <= '0;
      dout_q  <= '0;
    end else begin
      delay_q <= delay_d;
      mode_q  <= mode_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_filt
    inertial_filter_bit #(.DW(DW)) u_filt (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (mode_q == MODE_INERTIAL),
      .flush_i (bus.cfg_load),
      .din_i   (bus.din[i]),
      .dout_i  (dout_q[i]),
      .delay_i (delay_q),
      .dout_o  (filt_dout[i]),
      .drop_o  (drop[i])
    );
  end

  assign bus.dout         = dout_q;
  assign bus.pulse_drop   = drop;
  assign bus.active_delay = delay_q;
  assign bus.active_mode  = mode_q;

endmodule

// File: tb/tb_prim_delay_line.sv
// Directed plus randomized check of prim_delay_line against a sample-history model.
module tb_prim_delay_line;
  // MAX_DELAY=12 keeps delay_in 4 bits wide while leaving 13..15 to exercise the upper clamp.
  localparam int W    = 4;
  localparam int MAXD = 12;
  localparam int RSTD = 1;
  localparam int DW   = $clog2(MAXD + 1);

  logic clk = 1'b0;
  logic rst_n;

  prim_delay_line_if #(.WIDTH(W), .MAX_DELAY(MAXD)) bus ();

  prim_delay_line #(.WIDTH(W), .MAX_DELAY(MAXD), .RESET_DELAY(RSTD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] m_dout, m_drop;
  int           m_delay;
  logic         m_mode;
  logic [W-1:0] hist [MAXD];   // hist[k] = din sampled k edges before the latest
  int           run  [W];      // consecutive edges din[i] has disagreed with dout[i]

  task automatic model_edge(input logic [W-1:0] d, input logic cl, input int dl,
                            input logic md, input logic rn);
    logic [W-1:0] nd;
    if (!rn) begin
      m_dout = '0; m_drop = '0; m_delay = RSTD; m_mode = 1'b0;
      foreach (hist[k]) hist[k] = '0;
      foreach (run[i]) run[i] = 0;
    end else if (cl) begin
      m_delay = (dl == 0) ? 1 : ((dl > MAXD) ? MAXD : dl);
      m_mode  = md;
      m_drop  = '0;
      foreach (hist[k]) hist[k] = m_dout;
      foreach (run[i]) run[i] = 0;
    end else begin
      for (int k = MAXD - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = d;
      nd     = m_dout;
      m_drop = '0;
      if (!m_mode) nd = hist[m_delay-1];
      else begin
        for (int i = 0; i < W; i++) begin
          if (d[i] == m_dout[i]) begin
            m_drop[i] = (run[i] != 0);
            run[i] = 0;
          end else begin
            run[i]++;
            if (run[i] == m_delay) begin
              nd[i]  = d[i];
              run[i] = 0;
            end
          end
        end
      end
      m_dout = nd;
    end
  endtask

  task automatic check_all();
    logic [DW-1:0] exp_d;
    exp_d = m_delay[DW-1:0];
    vectors++;
    assert (bus.dout === m_dout) else begin
      miscompares++; $error("FAIL dout: got %h want %h", bus.dout, m_dout);
    end
    vectors++;
    assert (bus.pulse_drop === m_drop) else begin
      miscompares++; $error("FAIL pulse_drop: got %h want %h", bus.pulse_drop, m_drop);
    end
    vectors++;
    assert (bus.active_delay === exp_d) else begin
      miscompares++; $error("FAIL active_delay: got %0d want %0d", bus.active_delay, exp_d);
    end
    vectors++;
    assert (bus.active_mode === m_mode) else begin
      miscompares++; $error("FAIL active_mode: got %b want %b", bus.active_mode, m_mode);
    end
  endtask

  task automatic expect_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++; $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [W-1:0] d, input logic cl, input int dl,
                       input logic md, input logic rn);
    bus.din      = d;
    bus.cfg_load = cl;
    bus.delay_in = dl[DW-1:0];
    bus.mode_in  = md;
    rst_n        = rn;
    @(posedge clk);
    model_edge(d, cl, dl, md, rn);
    #1;
    check_all();
  endtask

  task automatic drive(input logic [W-1:0] d);
    apply(d, 1'b0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [W-1:0] rd;
    logic         rcl, rmd, rrn;
    int           rdl;

    // Reset held for two edges with din all ones
    apply(4'hF, 1'b0, 0, 1'b0, 1'b0);
    apply(4'hF, 1'b0, 0, 1'b0, 1'b0);
    expect_val("rst_dout", 8'(bus.dout), 8'h00);
    expect_val("rst_delay", 8'(bus.active_delay), 8'(RSTD));
    drive(4'hF);
    expect_val("release_dout", 8'(bus.dout), 8'h0F);

    // Transport D=3: word change and a 1-cycle bit0 pulse
    apply(4'hF, 1'b1, 3, 1'b0, 1'b1);
    repeat (3) drive(4'h0);
    drive(4'hA); drive(4'hA); drive(4'hA);
    expect_val("tr_latency", 8'(bus.dout), 8'h0A);
    drive(4'hA); drive(4'hA); drive(4'hB); drive(4'hA); drive(4'hA);
    expect_val("tr_pulse", 8'(bus.dout), 8'h0B);
    drive(4'hA);
    expect_val("tr_pulse_end", 8'(bus.dout), 8'h0A);

    // Inertial D=4: short pulse rejected, long pulse passes
    apply(4'hA, 1'b1, 4, 1'b1, 1'b1);
    repeat (5) drive(4'h0);
    drive(4'h2); drive(4'h2); drive(4'h0);
    expect_val("in_drop", 8'(bus.pulse_drop), 8'h02);
    drive(4'h0);
    drive(4'h2); drive(4'h2); drive(4'h2);
    expect_val("in_hold", 8'(bus.dout), 8'h00);
    drive(4'h2);
    expect_val("in_pass", 8'(bus.dout), 8'h02);

    // Clamp at both ends
    apply(4'h2, 1'b1, 0, 1'b0, 1'b1);
    expect_val("clamp_lo", 8'(bus.active_delay), 8'd1);
    drive(4'h5);
    expect_val("clamp_lo_lat", 8'(bus.dout), 8'h05);
    apply(4'h5, 1'b1, 15, 1'b0, 1'b1);
    expect_val("clamp_hi", 8'(bus.active_delay), 8'(MAXD));
    repeat (MAXD - 1) drive(4'h9);
    expect_val("clamp_hi_early", 8'(bus.dout), 8'h05);
    drive(4'h9);
    expect_val("clamp_hi_lat", 8'(bus.dout), 8'h09);

    // Reconfigure with transitions in flight
    apply(4'h9, 1'b1, 5, 1'b0, 1'b1);
    drive(4'h1); drive(4'h3); drive(4'h7);
    apply(4'h7, 1'b1, 2, 1'b0, 1'b1);
    expect_val("recfg_hold", 8'(bus.dout), 8'h09);
    drive(4'h4);
    expect_val("recfg_flush", 8'(bus.dout), 8'h09);
    drive(4'h4);
    expect_val("recfg_new", 8'(bus.dout), 8'h04);
    repeat (4) drive(4'h4);

    // Reset with an inertial count pending on bit2
    apply(4'h4, 1'b1, 8, 1'b1, 1'b1);
    repeat (5) drive(4'h0);
    apply(4'h0, 1'b0, 0, 1'b0, 1'b0);
    expect_val("midrst_dout", 8'(bus.dout), 8'h00);
    expect_val("midrst_mode", 8'(bus.active_mode), 8'h00);
    drive(4'h0);
    expect_val("midrst_nodrop", 8'(bus.pulse_drop), 8'h00);

    // Randomized traffic, slowly changing din so long pulses survive inertial mode
    rd = 4'h0;
    for (int s = 0; s < 600; s++) begin
      rrn = ($urandom_range(0, 79) != 0);
      rcl = ($urandom_range(0, 24) == 0);
      rdl = int'($urandom_range(0, 15));
      rmd = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) rd = W'($urandom);
      apply(rd, rcl, rdl, rmd, rrn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
